// File: rtl/fpga_gpio_cond.sv
// rtl/fpga_gpio_cond.sv - GPIO input conditioner: synchroniser, debounce, edge events, irq
//
// Purpose:
//   Per-channel conditioning of asynchronous GPIO pad inputs. Each pad goes
//   through a SYNC_STAGES flop chain, then a debounce filter producing the
//   filtered state f. Accepted changes of f raise one-cycle rise/fall pulses,
//   which (if enabled) set sticky event flags; masked events drive irq_o.
//
// Configuration macro:
//   GPIO_DEBOUNCE_EN - when defined, a per-channel counter requires
//                      DEBOUNCE_CYCLES stable cycles before f follows s.
//                      When undefined, no counters exist and f <= s each cycle.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   asynchronous active-high reset
//   gpio_pad_i  in   raw asynchronous pad levels
//   gpio_dir_i  in   1 = output (SoC drives), 0 = input
//   gpio_out_i  in   SoC output values
//   gpio_in_o   out  conditioned input value (or gpio_out_i when output)
//   rise_en_i   in   per-channel rising-edge event enable
//   fall_en_i   in   per-channel falling-edge event enable
//   evt_clr_i   in   per-channel sticky event clear (level)
//   irq_mask_i  in   per-channel interrupt enable
//   rise_o      out  one-cycle pulse when f becomes 1
//   fall_o      out  one-cycle pulse when f becomes 0
//   evt_o       out  sticky event flags
//   irq_o       out  registered OR of evt_o & irq_mask_i

module fpga_gpio_cond #(
    parameter int NUM_GPIO        = 32,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_GPIO-1:0] gpio_pad_i,
    input  logic [NUM_GPIO-1:0] gpio_dir_i,
    input  logic [NUM_GPIO-1:0] gpio_out_i,
    output logic [NUM_GPIO-1:0] gpio_in_o,
    input  logic [NUM_GPIO-1:0] rise_en_i,
    input  logic [NUM_GPIO-1:0] fall_en_i,
    input  logic [NUM_GPIO-1:0] evt_clr_i,
    input  logic [NUM_GPIO-1:0] irq_mask_i,
    output logic [NUM_GPIO-1:0] rise_o,
    output logic [NUM_GPIO-1:0] fall_o,
    output logic [NUM_GPIO-1:0] evt_o,
    output logic                irq_o
);

    // ------------------------------------------------------------------
    // Synchroniser chain
    // ------------------------------------------------------------------
    logic [NUM_GPIO-1:0] sync_q [SYNC_STAGES];
    logic [NUM_GPIO-1:0] sync_d [SYNC_STAGES];
    logic [NUM_GPIO-1:0] s;

    always_comb begin
        sync_d[0] = gpio_pad_i;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Filter: f follows s, optionally after DEBOUNCE_CYCLES stable cycles
    // ------------------------------------------------------------------
    logic [NUM_GPIO-1:0] f_q, f_d;
    logic [NUM_GPIO-1:0] upd;   // accepted change of f on an input channel

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q [NUM_GPIO];
    logic [CNT_W-1:0] cnt_d [NUM_GPIO];

    // The counter only advances while s differs from f and is cleared on
    // acceptance, so it tops out at CNT_LAST and can never wrap.
    always_comb begin
        f_d = f_q;
        upd = '0;
        for (int i = 0; i < NUM_GPIO; i++) begin
            cnt_d[i] = '0;
            if (gpio_dir_i[i]) begin
                // Output channel: shadow the pad silently so switching back
                // to input starts from a matched state.
                f_d[i] = s[i];
            end else if (s[i] != f_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    f_d[i] = s[i];
                    upd[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_GPIO; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_GPIO; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    always_comb begin
        f_d = s;
        upd = ~gpio_dir_i & (s ^ f_q);
    end
`endif

    // ------------------------------------------------------------------
    // Edge pulses, sticky events, interrupt
    // ------------------------------------------------------------------
    logic [NUM_GPIO-1:0] rise_q, rise_d;
    logic [NUM_GPIO-1:0] fall_q, fall_d;
    logic [NUM_GPIO-1:0] evt_q, evt_d;
    logic                irq_q, irq_d;

    always_comb begin
        // Pulses register alongside f so they coincide with the new level.
        rise_d = upd & s;
        fall_d = upd & ~s;
        // Set has priority over a simultaneous clear.
        evt_d  = (evt_q & ~evt_clr_i) | (rise_q & rise_en_i) | (fall_q & fall_en_i);
        irq_d  = |(evt_q & irq_mask_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q    <= '0;
            rise_q <= '0;
            fall_q <= '0;
            evt_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            f_q    <= f_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            evt_q  <= evt_d;
            irq_q  <= irq_d;
        end
    end

    assign gpio_in_o = (gpio_dir_i & gpio_out_i) | (~gpio_dir_i & f_q);
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign evt_o     = evt_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_fpga_gpio_cond.sv
// tb/tb_fpga_gpio_cond.sv - directed table-driven bench for fpga_gpio_cond

module tb_fpga_gpio_cond;

    localparam int N  = 4;
    localparam int SS = 2;
    localparam int DC = 4;
`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT    = SS + DC;
    localparam int RST_AT = SS + 2;
`else
    localparam int LAT    = SS + 1;
    localparam int RST_AT = 2;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] gpio_pad_i, gpio_dir_i, gpio_out_i, gpio_in_o;
    logic [N-1:0] rise_en_i, fall_en_i, evt_clr_i, irq_mask_i;
    logic [N-1:0] rise_o, fall_o, evt_o;
    logic         irq_o;

    int n_cmp  = 0;
    int n_fail = 0;

    fpga_gpio_cond #(
        .NUM_GPIO(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk(clk), .rst(rst),
        .gpio_pad_i(gpio_pad_i), .gpio_dir_i(gpio_dir_i), .gpio_out_i(gpio_out_i),
        .gpio_in_o(gpio_in_o),
        .rise_en_i(rise_en_i), .fall_en_i(fall_en_i), .evt_clr_i(evt_clr_i),
        .irq_mask_i(irq_mask_i),
        .rise_o(rise_o), .fall_o(fall_o), .evt_o(evt_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] pad;
        logic [N-1:0] dir;
        logic [N-1:0] out;
        logic [N-1:0] exp_in;
    } vec_t;

    vec_t tbl [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        int lat, nrise, nfall, nhigh, bad;
        logic r_at;

        tbl[0] = '{pad: 4'b0000, dir: 4'b0000, out: 4'b1111, exp_in: 4'b0000};
        tbl[1] = '{pad: 4'b1010, dir: 4'b0000, out: 4'b0000, exp_in: 4'b1010};
        tbl[2] = '{pad: 4'b1010, dir: 4'b1100, out: 4'b0101, exp_in: 4'b0110};
        tbl[3] = '{pad: 4'b0101, dir: 4'b1111, out: 4'b1001, exp_in: 4'b1001};
        tbl[4] = '{pad: 4'b0101, dir: 4'b0000, out: 4'b1001, exp_in: 4'b0101};
        tbl[5] = '{pad: 4'b1111, dir: 4'b0011, out: 4'b0000, exp_in: 4'b1100};
        tbl[6] = '{pad: 4'b0000, dir: 4'b0000, out: 4'b0000, exp_in: 4'b0000};

        rst = 1'b1;
        gpio_pad_i = '0; gpio_dir_i = '0; gpio_out_i = '0;
        rise_en_i = '0; fall_en_i = '0; evt_clr_i = '0; irq_mask_i = '0;

        // Reset state
        ticks(2);
        chk("reset_in",   gpio_in_o, 0);
        chk("reset_rise", rise_o, 0);
        chk("reset_fall", fall_o, 0);
        chk("reset_evt",  evt_o, 0);
        chk("reset_irq",  irq_o, 0);
        rst = 1'b0;
        tick();

        // Steady-state levels and direction mux
        for (int t = 0; t < 7; t++) begin
            gpio_pad_i = tbl[t].pad;
            gpio_dir_i = tbl[t].dir;
            gpio_out_i = tbl[t].out;
            ticks(LAT + 3);
            chk($sformatf("table_in[%0d]", t), gpio_in_o, tbl[t].exp_in);
            chk($sformatf("table_evt[%0d]", t), evt_o, 0);
        end

        // Rise latency on channel 0
        gpio_pad_i[0] = 1'b1;
        lat = -1; r_at = 1'b0;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            tick();
            if (gpio_in_o[0]) begin lat = k; r_at = rise_o[0]; end
        end
        chk("rise_latency", lat, LAT);
        chk("rise_pulse_at_update", r_at, 1);
        tick();
        chk("rise_pulse_one_cycle", rise_o[0], 0);
        chk("rise_level_held", gpio_in_o[0], 1);

        // Event set-wins-over-clear and irq timing
        gpio_pad_i[0] = 1'b0;
        ticks(LAT + 3);
        rise_en_i = 4'b0001; irq_mask_i = 4'b0001;
        chk("evt_no_fall_evt", evt_o, 0);
        gpio_pad_i[0] = 1'b1;
        lat = -1;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            tick();
            if (rise_o[0]) lat = k;
        end
        chk("evt_rise_seen", lat, LAT);
        evt_clr_i[0] = 1'b1;
        tick();
        chk("evt_set_wins", evt_o, 4'b0001);
        chk("irq_not_yet", irq_o, 0);
        evt_clr_i[0] = 1'b0;
        tick();
        chk("irq_set", irq_o, 1);
        chk("evt_sticky", evt_o, 4'b0001);
        evt_clr_i[0] = 1'b1;
        tick();
        chk("evt_cleared", evt_o, 0);
        chk("irq_lags_clear", irq_o, 1);
        evt_clr_i[0] = 1'b0;
        tick();
        chk("irq_cleared", irq_o, 0);
        rise_en_i = '0; irq_mask_i = '0;
        gpio_pad_i[0] = 1'b0;
        ticks(LAT + 3);

        // Output direction: pad toggling is invisible, no pulses on return
        gpio_dir_i[2] = 1'b1; gpio_out_i[2] = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            gpio_pad_i[2] = ~gpio_pad_i[2];
            tick();
            if (gpio_in_o[2] !== 1'b1 || rise_o[2] || fall_o[2]) bad++;
        end
        chk("dir_out_toggle_bad_cycles", bad, 0);
        gpio_pad_i[2] = 1'b1;
        ticks(SS + 3);
        gpio_dir_i[2] = 1'b0;
        bad = 0;
        for (int k = 0; k < LAT + 4; k++) begin
            tick();
            if (gpio_in_o[2] !== 1'b1 || rise_o[2] || fall_o[2]) bad++;
        end
        chk("dir_return_bad_cycles", bad, 0);
        gpio_pad_i[2] = 1'b0;
        ticks(LAT + 3);

        // Reset in the middle of a pending change
        gpio_pad_i[0] = 1'b1;
        ticks(RST_AT);
        rst = 1'b1;
        #1;
        chk("midrst_in",   gpio_in_o, 0);
        chk("midrst_rise", rise_o, 0);
        chk("midrst_fall", fall_o, 0);
        chk("midrst_evt",  evt_o, 0);
        chk("midrst_irq",  irq_o, 0);
        ticks(2);
        rst = 1'b0;
        lat = -1; nrise = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (gpio_in_o[0] && lat < 0) lat = k;
            if (rise_o[0]) nrise++;
        end
        chk("postrst_latency", lat, LAT);
        chk("postrst_rise_count", nrise, 1);
        gpio_pad_i[0] = 1'b0;
        ticks(LAT + 3);

`ifdef GPIO_DEBOUNCE_EN
        // Short glitch must be filtered
        gpio_pad_i[1] = 1'b1;
        ticks(3);
        gpio_pad_i[1] = 1'b0;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (gpio_in_o[1] || rise_o[1] || fall_o[1]) bad++;
        end
        chk("glitch_filtered", bad, 0);
`else
        // One-cycle pad pulse passes straight through
        gpio_pad_i[3] = 1'b1;
        tick();
        gpio_pad_i[3] = 1'b0;
        lat = -1; nhigh = 0; nrise = 0; nfall = 0;
        for (int k = 1; k <= 10; k++) begin
            if (gpio_in_o[3]) begin
                nhigh++;
                if (lat < 0) lat = k;
            end
            if (rise_o[3]) nrise++;
            if (fall_o[3]) nfall++;
            tick();
        end
        chk("pulse_first_high", lat, SS + 1);
        chk("pulse_high_cycles", nhigh, 1);
        chk("pulse_rise_count", nrise, 1);
        chk("pulse_fall_count", nfall, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
